ft_frame_parser: RTL

//  Consumes 16-bit words from the FT600 mode-245 RX FIFO (first-word-fall-through) and delineates host frames.

---
 rtl/ft_frame_parser_pkg.sv | 13 +
 rtl/ft_frame_parser_timeout.sv | 30 +++
 rtl/ft_frame_parser.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ft_frame_parser_pkg.sv
// Shared types for the FT600 RX frame parser: FSM state encoding and the default sync byte.
package ft_frame_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CSUM    = 2'd3
   } state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/ft_frame_parser_timeout.sv
// Mid-frame inactivity timer: counts enabled cycles since the last clear, pulses on the final count.
module ft_frame_timeout #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   // A clear in the expiry cycle means a word was popped, which takes priority.
   assign o_expire = i_enable & ~i_clear & (r_cnt == LAST);

endmodule

// File: rtl/ft_frame_parser.sv
// Delineates host frames from the FT600 RX FIFO, streams payload words and verifies the checksum.
module ft_frame_parser
   import ft_frame_pkg::*;
#(
   parameter int         MAX_LEN = 256,
   parameter int         TIMEOUT = 4096,
   parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in_data,
   input  logic        in_empty,
   output logic        in_rd,
   output logic [15:0] out_data,
   output logic        out_valid,
   output logic        out_last,
   input  logic        out_ready,
   output logic [7:0]  frame_cmd,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

   state_t      r_state;
   logic [15:0] r_sum;
   logic [15:0] r_rem;
   logic        w_rd;
   logic        w_expire;
   logic        w_timer_clr;
   logic        w_timer_en;

   // Payload pops stall only while the output register holds an unaccepted word.
   always_comb begin
      w_rd = !in_empty;
      if (r_state == ST_PAYLOAD) begin
         w_rd = !in_empty && (!out_valid || out_ready);
      end
   end

   assign in_rd       = w_rd;
   assign w_timer_clr = w_rd || (r_state == ST_HUNT);
   assign w_timer_en  = (r_state != ST_HUNT);

   ft_frame_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_timer_clr),
      .i_enable (w_timer_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_HUNT;
         r_sum     <= '0;
         r_rem     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_cmd <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         // The output register keeps draining after an abort; only the frame is dropped.
         if (w_expire) begin
            frame_err <= 1'b1;
            bad_cnt   <= bad_cnt + 16'd1;
            r_state   <= ST_HUNT;
         end else if (w_rd) begin
            case (r_state)
               ST_HUNT: begin
                  if (in_data[15:8] == SYNC) begin
                     r_sum     <= in_data;
                     frame_cmd <= in_data[7:0];
                     r_state   <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  r_sum <= r_sum + in_data;
                  if (in_data > MAX_LEN16) begin
                     frame_err <= 1'b1;
                     bad_cnt   <= bad_cnt + 16'd1;
                     r_state   <= ST_HUNT;
                  end else if (in_data == 16'd0) begin
                     r_state <= ST_CSUM;
                  end else begin
                     r_rem   <= in_data;
                     r_state <= ST_PAYLOAD;
                  end
               end
               ST_PAYLOAD: begin
                  r_sum     <= r_sum + in_data;
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  out_last  <= (r_rem == 16'd1);
                  r_rem     <= r_rem - 16'd1;
                  if (r_rem == 16'd1) begin
                     r_state <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  if (16'(r_sum + in_data) == 16'd0) begin
                     frame_ok <= 1'b1;
                     good_cnt <= good_cnt + 16'd1;
                  end else begin
                     frame_err <= 1'b1;
                     bad_cnt   <= bad_cnt + 16'd1;
                  end
                  r_state <= ST_HUNT;
               end
               default: r_state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule
